// File: rtl/output_uart_pkg.sv
// Shared definitions for the output-buffer UART transmitter and the memory block.
package output_uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } uart_tx_state_t;

    localparam int          UART_DATA_BITS         = 8;
    localparam logic        UART_IDLE_LEVEL        = 1'b1;

    // Memory-mapped addresses of the output byte buffer, shared with the memory block.
    localparam logic [31:0] OUTPUT_BYTES_ADDR      = 32'h8000_0004;
    localparam logic [31:0] OUTPUT_BYTES_AVAI_ADDR = 32'h8000_0000;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts while run is high, wraps at CLK_PER_BIT-1 and
// flags that last cycle of each bit period with bit_tick.
module uart_baud_counter #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic bit_tick
);

    localparam int               CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_tick = run && (cnt_q == LAST);

    // Next count: clear has priority, otherwise count and wrap on the last cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = bit_tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/output_uart_tx.sv
// Drains the output byte buffer one byte at a time and sends each byte as an
// 8N1 frame, LSB first, on uart_tx.
module output_uart_tx
    import output_uart_pkg::*;
#(
    parameter int CLK_PER_BIT      = 868,
    parameter int BUFFER_BYTE_SIZE = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tx_enable,
    input  logic [31:0] io_buffer_size_avai,
    input  logic [7:0]  io_output_data,
    output logic        io_output_en,
    output logic        uart_tx,
    output logic        busy,
    output logic        tx_done
);

    uart_tx_state_t state_q;
    logic [7:0]     shift_q;
    logic [2:0]     bit_cnt_q;
    logic           bit_tick;
    logic           baud_clear;
    logic           baud_run;
    logic           pending;

    // An avai value above the capacity fails this compare and reads as empty.
    assign pending = io_buffer_size_avai < 32'(BUFFER_BYTE_SIZE);

    // The counter is held at zero through IDLE/LOAD so START begins a fresh
    // period; DATA and STOP are entered on a wrap, so they also start at zero.
    assign baud_clear = (state_q == IDLE) || (state_q == LOAD);
    assign baud_run   = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    uart_baud_counter #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (baud_clear),
        .run      (baud_run),
        .bit_tick (bit_tick)
    );

    // Frame sequencer: pop in LOAD, then start bit, eight data bits, stop bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_enable && pending) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    shift_q <= io_output_data;
                    state_q <= START;
                end
                START: begin
                    if (bit_tick) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Line level decoded from registered state only; reset forces idle high.
    always_comb begin
        uart_tx = UART_IDLE_LEVEL;
        case (state_q)
            START:   uart_tx = 1'b0;
            DATA:    uart_tx = shift_q[0];
            default: uart_tx = UART_IDLE_LEVEL;
        endcase
    end

    assign io_output_en = (state_q == LOAD);
    assign busy         = (state_q != IDLE);
    assign tx_done      = (state_q == STOP) && bit_tick;

endmodule

// File: tb/tb_output_uart_tx.sv
// Self-checking bench for output_uart_tx: a queue models the output buffer,
// and an abstract frame-timing model predicts every output on every cycle.
module tb_output_uart_tx;

    localparam int C   = 4;
    localparam int BUF = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tx_enable = 1'b0;
    logic [31:0] io_buffer_size_avai = 32'd32;
    logic [7:0]  io_output_data = 8'h00;
    logic        io_output_en;
    logic        uart_tx;
    logic        busy;
    logic        tx_done;

    output_uart_tx #(.CLK_PER_BIT(C), .BUFFER_BYTE_SIZE(BUF)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .tx_enable           (tx_enable),
        .io_buffer_size_avai (io_buffer_size_avai),
        .io_output_data      (io_output_data),
        .io_output_en        (io_output_en),
        .uart_tx             (uart_tx),
        .busy                (busy),
        .tx_done             (tx_done)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] q[$];
    int         avai_ovr = -1;
    int         pops = 0;
    int         dones = 0;
    int         en_cycles[$];
    int         done_cycles[$];

    // Frame model: a frame is described only by its LOAD cycle and its byte.
    bit         m_act = 1'b0;
    int         m_L = 0;
    logic [7:0] m_byte = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic refresh();
        io_buffer_size_avai = (avai_ovr >= 0) ? avai_ovr : BUF - q.size();
        io_output_data      = (q.size() > 0) ? q[0] : 8'h00;
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, let the
    // buffer pop after the edge, then return in the input phase of the next cycle.
    task automatic step();
        logic e_tx, e_en, e_busy, e_done, popped;
        int d;
        @(negedge clk);
        if (!reset_n) m_act = 1'b0;
        e_tx = 1'b1; e_en = 1'b0; e_busy = 1'b0; e_done = 1'b0; d = -1;
        if (m_act) begin
            d = cyc - m_L;
            e_busy = 1'b1;
            if (d == 0) begin
                e_en = 1'b1;
                m_byte = (q.size() > 0) ? q[0] : 8'h00;
            end else if (d <= C) begin
                e_tx = 1'b0;
            end else if (d <= 9 * C) begin
                e_tx = m_byte[(d - 1) / C - 1];
            end
            if (d == 10 * C) e_done = 1'b1;
        end
        chk("uart_tx", uart_tx, e_tx);
        chk("io_output_en", io_output_en, e_en);
        chk("busy", busy, e_busy);
        chk("tx_done", tx_done, e_done);
        popped = io_output_en;
        if (io_output_en) begin pops++; en_cycles.push_back(cyc); end
        if (tx_done) begin dones++; done_cycles.push_back(cyc); end
        if (!reset_n) begin
            m_act = 1'b0;
        end else if (m_act) begin
            if (d == 10 * C) m_act = 1'b0;
        end else if (tx_enable && io_buffer_size_avai < BUF) begin
            m_act = 1'b1;
            m_L = cyc + 1;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (popped && q.size() > 0) void'(q.pop_front());
        refresh();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        avai_ovr = -1;
        refresh();
        repeat (3) step();
        reset_n = 1'b1;
        step();
    endtask

    typedef struct {
        string      name;
        int         nbytes;
        logic [7:0] b0, b1, b2;
        int         ovr;
        int         ncyc;
        int         exp_pops;
        int         exp_dones;
        int         exp_en_off;   // first pop relative to push cycle, -1 if none
        int         exp_done_off; // first tx_done relative to push cycle, -1 if none
    } vec_t;

    vec_t vecs[4];

    initial begin
        int c0, p0, d0, ce, pushed;

        vecs[0] = '{"byte55",  1, 8'h55, 8'h00, 8'h00, -1,  60, 1, 1,  1, 41};
        vecs[1] = '{"empty",   0, 8'h00, 8'h00, 8'h00, -1, 200, 0, 0, -1, -1};
        vecs[2] = '{"avai33",  0, 8'h00, 8'h00, 8'h00, 33, 100, 0, 0, -1, -1};
        vecs[3] = '{"three",   3, 8'hA5, 8'h00, 8'hFF, -1, 140, 3, 3,  1, 41};

        refresh();
        repeat (2) step();
        chk("reset_uart_tx", uart_tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_en", io_output_en, 1'b0);
        chk("reset_done", tx_done, 1'b0);

        // Table-driven scenarios.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            tx_enable = 1'b1;
            if (vecs[i].nbytes > 0) q.push_back(vecs[i].b0);
            if (vecs[i].nbytes > 1) q.push_back(vecs[i].b1);
            if (vecs[i].nbytes > 2) q.push_back(vecs[i].b2);
            avai_ovr = vecs[i].ovr;
            refresh();
            en_cycles.delete();
            done_cycles.delete();
            c0 = cyc; p0 = pops; d0 = dones;
            repeat (vecs[i].ncyc) step();
            chk({vecs[i].name, "_pops"}, pops - p0, vecs[i].exp_pops);
            chk({vecs[i].name, "_dones"}, dones - d0, vecs[i].exp_dones);
            chk({vecs[i].name, "_first_en"},
                (en_cycles.size() > 0) ? en_cycles[0] - c0 : -1, vecs[i].exp_en_off);
            chk({vecs[i].name, "_first_done"},
                (done_cycles.size() > 0) ? done_cycles[0] - c0 : -1, vecs[i].exp_done_off);
            if (vecs[i].nbytes == 3) begin
                chk("spacing01", (en_cycles.size() > 1) ? en_cycles[1] - en_cycles[0] : -1, 42);
                chk("spacing12", (en_cycles.size() > 2) ? en_cycles[2] - en_cycles[1] : -1, 42);
            end
            avai_ovr = -1;
            refresh();
        end

        // tx_enable dropped during DATA of the first of two queued bytes.
        do_reset();
        tx_enable = 1'b1;
        q.push_back(8'h3C);
        q.push_back(8'hC3);
        refresh();
        c0 = cyc; p0 = pops; d0 = dones;
        en_cycles.delete();
        repeat (21) step();
        chk("drop_in_data_busy", busy, 1'b1);
        tx_enable = 1'b0;
        repeat (60) step();
        chk("drop_pops", pops - p0, 1);
        chk("drop_dones", dones - d0, 1);
        ce = cyc;
        tx_enable = 1'b1;
        repeat (5) step();
        chk("resume_pops", pops - p0, 2);
        chk("resume_load", (en_cycles.size() > 1) ? en_cycles[1] - ce : -1, 1);
        repeat (45) step();
        chk("resume_dones", dones - d0, 2);

        // Reset pulsed during data bit 3, then a fresh frame.
        do_reset();
        tx_enable = 1'b1;
        q.push_back(8'h00);
        refresh();
        step();
        for (int k = 0; k < 40 && !(m_act && cyc == m_L + 1 + 4 * C + 1); k++) step();
        chk("pre_reset_busy", busy, 1'b1);
        chk("pre_reset_tx", uart_tx, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("async_reset_tx", uart_tx, 1'b1);
        chk("async_reset_busy", busy, 1'b0);
        p0 = pops; d0 = dones;
        q.delete();
        refresh();
        repeat (3) step();
        chk("no_pop_in_reset", pops - p0, 0);
        reset_n = 1'b1;
        q.push_back(8'h96);
        refresh();
        chk("post_reset_avai", io_buffer_size_avai, 31);
        repeat (50) step();
        chk("post_reset_pops", pops - p0, 1);
        chk("post_reset_dones", dones - d0, 1);

        // Randomised traffic with enable toggling, checked every cycle by the model.
        do_reset();
        tx_enable = 1'b1;
        p0 = pops; pushed = 0;
        repeat (1500) begin
            step();
            if ($urandom_range(0, 19) == 0 && q.size() < BUF) begin
                q.push_back(8'($urandom));
                pushed++;
            end
            if ($urandom_range(0, 59) == 0) tx_enable = ~tx_enable;
            refresh();
        end
        tx_enable = 1'b1;
        repeat ((BUF + 1) * (10 * C + 2) + 20) step();
        chk("rand_pops", pops - p0, pushed);
        chk("rand_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
